// File: rtl/secded_pipe_codec_if.sv
// Handshake and status bundle for the SECDED encode/inject/decode pipeline.
// The codec uses the slave modport; a producer/consumer uses the master modport.
interface secded_pipe_codec_if #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 16
);
    // Smallest r with 2^r >= DATA_W + r + 1 over the supported width range.
    localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6;
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        inject_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [PAR_W-1:0]  out_syndrome;
    logic [CODE_W-1:0] out_flip_mask;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;
    logic              clear_cnt;

    modport slave (
        input  in_valid, in_data, inject_mode, out_ready, clear_cnt,
        output in_ready, out_valid, out_data, out_status, out_syndrome,
               out_flip_mask, corr_cnt, uncorr_cnt
    );

    modport master (
        output in_valid, in_data, inject_mode, out_ready, clear_cnt,
        input  in_ready, out_valid, out_data, out_status, out_syndrome,
               out_flip_mask, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/secded_pipe_codec.sv
// Three-stage SECDED datapath: extended-Hamming encode, LFSR-driven bit-flip
// injection, syndrome decode/correct, with a single global stall and error counters.
module secded_pipe_codec #(
    parameter int          DATA_W    = 7,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'h0001
) (
    input logic                clk,
    input logic                rst,
    secded_pipe_codec_if.slave bus
);
    localparam int          PAR_W     = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6;
    localparam int          CODE_W    = DATA_W + PAR_W + 1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Data bits fill non-power-of-two Hamming positions; parity bits have a single
    // set position bit, so each parity accumulates only from data positions.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              par;
        int                k;
        c = '0;
        k = 0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (((i + 1) & i) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int p = 0; p < PAR_W; p++) begin
            par = 1'b0;
            for (int i = 0; i < CODE_W - 1; i++)
                if ((((i + 1) >> p) & 1) != 0) par ^= c[i];
            c[(1 << p) - 1] = par;
        end
        c[CODE_W-1] = ^c[CODE_W-2:0];
        return c;
    endfunction

    function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] c);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 0; i < CODE_W - 1; i++)
            if (c[i]) s ^= PAR_W'(i + 1);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (((i + 1) & i) != 0) begin
                d[k] = c[i];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [CODE_W-1:0] flip_mask(input logic [15:0] s, input logic [1:0] mode);
        logic [CODE_W-1:0] m;
        int                p1;
        int                p2;
        p1 = int'(s[7:0]) % CODE_W;
        p2 = int'(s[15:8]) % CODE_W;
        if (p2 == p1) p2 = (p1 + 1) % CODE_W;
        m = '0;
        if (mode == 2'b01) begin
            m[p1] = 1'b1;
        end else if (mode == 2'b10) begin
            m[p1] = 1'b1;
            m[p2] = 1'b1;
        end
        return m;
    endfunction

    logic              en;
    logic              acc;
    logic [15:0]       lfsr;
    logic              vld_p0;
    logic              vld_p1;
    logic [CODE_W-1:0] code_p0;
    logic [CODE_W-1:0] mask_p0;
    logic [CODE_W-1:0] inj_p1;
    logic [CODE_W-1:0] mask_p1;
    logic [CODE_W-1:0] fix_p1;
    logic [PAR_W-1:0]  syn_p1;
    logic [1:0]        status_p1;
    logic              hs;

    assign en           = !bus.out_valid || bus.out_ready;
    assign acc          = bus.in_valid && en;
    assign bus.in_ready = en;
    assign hs           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      lfsr <= LFSR_SEED;
        else if (acc) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
        end
    end

    // stage p0: encode and capture the injection mask; stage p1: apply the flips
    always_ff @(posedge clk) begin
        if (en) begin
            code_p0 <= encode(bus.in_data);
            mask_p0 <= flip_mask(lfsr, bus.inject_mode);
            inj_p1  <= code_p0 ^ mask_p0;
            mask_p1 <= mask_p0;
        end
    end

    // stage p1 -> p2 boundary: decode the received word
    always_comb begin
        syn_p1    = syndrome(inj_p1);
        fix_p1    = inj_p1;
        status_p1 = 2'b00;
        if (^inj_p1) begin
            if (syn_p1 == '0) begin
                status_p1 = 2'b01;
            end else if (int'(syn_p1) <= CODE_W - 1) begin
                for (int i = 0; i < CODE_W - 1; i++)
                    if (int'(syn_p1) == i + 1) fix_p1[i] = ~inj_p1[i];
                status_p1 = 2'b01;
            end else begin
                status_p1 = 2'b10;
            end
        end else if (syn_p1 != '0) begin
            status_p1 = 2'b10;
        end
    end

    // stage p2: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.out_status    <= 2'b00;
            bus.out_syndrome  <= '0;
            bus.out_flip_mask <= '0;
        end else if (en) begin
            bus.out_valid     <= vld_p1;
            bus.out_data      <= extract(fix_p1);
            bus.out_status    <= status_p1;
            bus.out_syndrome  <= syn_p1;
            bus.out_flip_mask <= mask_p1;
        end
    end

    // Clear has priority over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.corr_cnt   <= '0;
            bus.uncorr_cnt <= '0;
        end else if (bus.clear_cnt) begin
            bus.corr_cnt   <= '0;
            bus.uncorr_cnt <= '0;
        end else if (hs) begin
            if (bus.out_status == 2'b01 && bus.corr_cnt != '1)
                bus.corr_cnt <= bus.corr_cnt + 1'b1;
            if (bus.out_status == 2'b10 && bus.uncorr_cnt != '1)
                bus.uncorr_cnt <= bus.uncorr_cnt + 1'b1;
        end
    end
endmodule
